// File: rtl/rotary_cell_pkg.sv
// rtl/rotary_cell_pkg.sv - shared states, pump pattern and isolation-valve constants for rotary_cell_ctrl
package rotary_cell_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MIX  = 3'd2,
        ST_DISP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int N_STEPS = 6;

    // Forward peristaltic sequence; one full pump cycle is all six entries.
    localparam logic [2:0] PUMP_PAT [N_STEPS] = '{
        3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010
    };

    // All three pump valves closed-to-open while the mixer fills.
    localparam logic [2:0] PUMP_LOAD = 3'b111;

    // Isolation valves: [0] inlet side, [1] outlet side.
    localparam logic [1:0] ISO_LOAD = 2'b01;
    localparam logic [1:0] ISO_MIX  = 2'b00;
    localparam logic [1:0] ISO_DISP = 2'b10;

endpackage

// File: rtl/rotary_pump_seq.sv
// rtl/rotary_pump_seq.sv - phase/step/round counters and pump pattern lookup (optional ROTARY_REVERSE_EN)
module rotary_pump_seq #(
    parameter int STEP_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] rounds,
    input  logic       reverse,
    output logic [2:0] pump_valve,
    output logic       rounds_done
);
    import rotary_cell_pkg::*;

    localparam int PW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(STEP_CYC - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    step_q, step_d;
    logic [7:0]    round_q, round_d;
    logic          phase_last, step_last;

    assign phase_last = (phase_q == PH_LAST);
    assign step_last  = (step_q == 3'd5);

    // Next counter values; pump_valve is looked up from these so the parent can register it.
    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
        round_d = round_q;
        if (clr) begin
            phase_d = '0;
            step_d  = '0;
            round_d = '0;
        end else if (en) begin
            if (phase_last) begin
                phase_d = '0;
                if (step_last) begin
                    step_d  = '0;
                    round_d = round_q + 8'd1;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            step_q  <= '0;
            round_q <= '0;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
            round_q <= round_d;
        end
    end

    // High during the final cycle of the last requested round.
    assign rounds_done = en & phase_last & step_last & (round_q == rounds - 8'd1);

`ifdef ROTARY_REVERSE_EN
    logic [2:0] step_idx;
    assign step_idx   = (reverse && round_d[0]) ? (3'd5 - step_d) : step_d;
    assign pump_valve = PUMP_PAT[step_idx];
`else
    logic unused_reverse;
    assign unused_reverse = reverse;
    assign pump_valve     = PUMP_PAT[step_d];
`endif

endmodule

// File: rtl/rotary_cell_ctrl.sv
// rtl/rotary_cell_ctrl.sv - LOAD/MIX/DISPENSE sequencer for the rotary mixer cell chip (optional ROTARY_REVERSE_EN)
module rotary_cell_ctrl #(
    parameter int N_IN        = 4,
    parameter int N_TRAPS     = 4,
    parameter int STEP_CYC    = 16,
    parameter int LOAD_CYC    = 64,
    parameter int DISP_ROUNDS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(N_IN)-1:0]    in_sel,
    input  logic [$clog2(N_TRAPS)-1:0] trap_sel,
    input  logic [7:0]                 mix_rounds,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       aborted,
    output logic [N_IN-1:0]            in_valve,
    output logic [N_TRAPS-1:0]         trap_valve,
    output logic [1:0]                 iso_valve,
    output logic [2:0]                 pump_valve,
    output logic [2:0]                 state
);
    import rotary_cell_pkg::*;

    localparam int IW = $clog2(N_IN);
    localparam int TW = $clog2(N_TRAPS);
    localparam int LW = $clog2(LOAD_CYC + 1);
    localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYC - 1);
    localparam logic [7:0]    DISP_R8   = 8'(DISP_ROUNDS);

    state_e        st_q, st_d;
    logic [IW-1:0] in_q;
    logic [TW-1:0] trap_q;
    logic [7:0]    rounds_q;
    logic [LW-1:0] load_cnt_q, load_cnt_d;

    logic cmd_ok, accept, reject, abort_hit, done_hit;
    logic seq_en, seq_clr, seq_rev, seq_done;
    logic [7:0] seq_rounds;
    logic [2:0] seq_pump;

    logic [IW-1:0]      in_idx_n;
    logic [N_IN-1:0]    in_valve_n;
    logic [N_TRAPS-1:0] trap_valve_n;
    logic [1:0]         iso_valve_n;
    logic [2:0]         pump_valve_n;
    logic               busy_n;

    assign cmd_ok     = (32'(in_sel) < N_IN) && (32'(trap_sel) < N_TRAPS);
    assign seq_en     = (st_q == ST_MIX) || (st_q == ST_DISP);
    assign seq_rounds = (st_q == ST_MIX) ? rounds_q : DISP_R8;
    assign state      = st_q;

`ifdef ROTARY_REVERSE_EN
    assign seq_rev = (st_d == ST_MIX);
`else
    assign seq_rev = 1'b0;
`endif

    rotary_pump_seq #(
        .STEP_CYC (STEP_CYC)
    ) u_pump_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (seq_en),
        .clr         (seq_clr),
        .rounds      (seq_rounds),
        .reverse     (seq_rev),
        .pump_valve  (seq_pump),
        .rounds_done (seq_done)
    );

    // Next-state: command capture, phase sequencing, abort override.
    always_comb begin
        st_d       = st_q;
        accept     = 1'b0;
        reject     = 1'b0;
        abort_hit  = 1'b0;
        done_hit   = 1'b0;
        seq_clr    = 1'b0;
        load_cnt_d = load_cnt_q;
        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    if (cmd_ok) begin
                        accept     = 1'b1;
                        load_cnt_d = '0;
                        st_d       = ST_LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
                    seq_clr = 1'b1;
                    st_d    = (rounds_q == 8'd0) ? ST_DISP : ST_MIX;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            ST_MIX: begin
                if (seq_done) begin
                    seq_clr = 1'b1;
                    st_d    = ST_DISP;
                end
            end
            ST_DISP: begin
                if (seq_done) begin
                    done_hit = 1'b1;
                    st_d     = ST_DONE;
                end
            end
            ST_DONE: st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
        if (abort && (st_q == ST_LOAD || st_q == ST_MIX || st_q == ST_DISP)) begin
            abort_hit = 1'b1;
            done_hit  = 1'b0;
            seq_clr   = 1'b1;
            st_d      = ST_IDLE;
        end
    end

    // Valve values for the state being entered, so every output comes straight from a flop.
    always_comb begin
        in_idx_n     = accept ? in_sel : in_q;
        in_valve_n   = '0;
        trap_valve_n = '0;
        iso_valve_n  = ISO_MIX;
        pump_valve_n = '0;
        busy_n       = 1'b0;
        case (st_d)
            ST_LOAD: begin
                in_valve_n   = N_IN'(1) << in_idx_n;
                iso_valve_n  = ISO_LOAD;
                pump_valve_n = PUMP_LOAD;
                busy_n       = 1'b1;
            end
            ST_MIX: begin
                iso_valve_n  = ISO_MIX;
                pump_valve_n = seq_pump;
                busy_n       = 1'b1;
            end
            ST_DISP: begin
                trap_valve_n = N_TRAPS'(1) << trap_q;
                iso_valve_n  = ISO_DISP;
                pump_valve_n = seq_pump;
                busy_n       = 1'b1;
            end
            default: ;
        endcase
    end

    // State register and LOAD dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            load_cnt_q <= '0;
        end else begin
            st_q       <= st_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    // Command latch; later changes on the inputs do not disturb a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q     <= '0;
            trap_q   <= '0;
            rounds_q <= '0;
        end else if (accept) begin
            in_q     <= in_sel;
            trap_q   <= trap_sel;
            rounds_q <= mix_rounds;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            aborted    <= 1'b0;
            in_valve   <= '0;
            trap_valve <= '0;
            iso_valve  <= '0;
            pump_valve <= '0;
        end else begin
            busy       <= busy_n;
            done       <= done_hit;
            err        <= reject;
            aborted    <= abort_hit;
            in_valve   <= in_valve_n;
            trap_valve <= trap_valve_n;
            iso_valve  <= iso_valve_n;
            pump_valve <= pump_valve_n;
        end
    end

endmodule
